trng_health_fifo: RTL

- Downstream consumer of the raw TRNG byte core; replaces the direct Wishbone-to-core path with a health-tested, buffered source.
- Samples raw bytes and runs SP800-90B-style repetition-count (RCT) and adaptive-proportion (APT) tests.
- Buffers passing bytes in a FIFO and serves them to software over an 8-bit Wishbone classic slave.

---
 rtl/trng_pkg.sv | 22 ++
 rtl/trng_byte_fifo.sv | 93 +++++++++
 rtl/trng_health_fifo.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/trng_pkg.sv
// Shared constants for the health-tested TRNG byte source: Wishbone register
// offsets and the bit positions inside the STATUS and CTRL registers.
package trng_pkg;

  // Register offsets, decoded from wb_adr_i[1:0]
  localparam logic [1:0] TRNG_REG_DATA   = 2'd0;
  localparam logic [1:0] TRNG_REG_STATUS = 2'd1;
  localparam logic [1:0] TRNG_REG_LEVEL  = 2'd2;
  localparam logic [1:0] TRNG_REG_CTRL   = 2'd3;

  // STATUS bit indices
  localparam int unsigned STATUS_EMPTY    = 0;
  localparam int unsigned STATUS_FULL     = 1;
  localparam int unsigned STATUS_RCT_FAIL = 2;
  localparam int unsigned STATUS_APT_FAIL = 3;
  localparam int unsigned STATUS_ENABLE   = 4;

  // CTRL bit indices
  localparam int unsigned CTRL_ENABLE = 0;
  localparam int unsigned CTRL_CLEAR  = 1;

endpackage

// File: rtl/trng_byte_fifo.sv
// Synchronous byte FIFO with a registered head.
//   clk_i    clock
//   rst_ni   synchronous active-low reset
//   flush_i  empties the FIFO; overrides push and pop
//   push_i   write wdata_i (ignored when full)
//   pop_i    drop the head (ignored when empty)
//   wdata_i  byte to push
//   head_o   oldest stored byte, valid when not empty
//   fill_o   number of stored entries
//   empty_o  / full_o  occupancy flags
module trng_byte_fifo #(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [7:0]                   wdata_i,
  output logic [7:0]                   head_o,
  output logic [$clog2(FIFO_DEPTH):0]  fill_o,
  output logic                         empty_o,
  output logic                         full_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned FW = AW + 1;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [7:0]    head_q, head_d;
  logic          do_push, do_pop;
  logic [AW-1:0] rd_next;

  assign empty_o = (fill_q == '0);
  assign full_o  = (fill_q == FW'(FIFO_DEPTH));
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  // Depth is a power of two, so pointers wrap on their own
  assign rd_next = rd_ptr_q + AW'(1);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    head_d   = head_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
      head_d   = 8'h00;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_next;
      fill_d = fill_q + FW'(do_push) - FW'(do_pop);
      if (do_pop) begin
        // Popping the last entry: a simultaneous push becomes the new head
        if (fill_q == FW'(1)) begin
          if (do_push) head_d = wdata_i;
        end else begin
          head_d = mem_q[rd_next];
        end
      end else if (do_push && empty_o) begin
        head_d = wdata_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      head_q   <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      head_q   <= head_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by fill_q
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o = head_q;
  assign fill_o = fill_q;

endmodule

// File: rtl/trng_health_fifo.sv
// Health-tested, buffered TRNG byte source behind an 8-bit Wishbone classic
// slave. Raw samples run through a repetition-count test (RCT) and an
// adaptive-proportion test (APT); passing samples are queued in a FIFO.
//   wb_clk, wb_rst          clock and synchronous active-low reset
//   wb_adr_i .. wb_bte_i    Wishbone slave inputs (only adr[1:0] decoded)
//   wb_dat_o, wb_ack_o,
//   wb_err_o, wb_rty_o      registered Wishbone responses (rty tied 0)
//   raw_en                  registered sample request to the raw core
//   raw_valid, raw_dat      raw sample from the core
module trng_health_fifo
  import trng_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned RCT_CUTOFF = 4,
  parameter int unsigned APT_WINDOW = 64,
  parameter int unsigned APT_CUTOFF = 13
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic [31:0] wb_adr_i,
  input  logic [7:0]  wb_dat_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  output logic [7:0]  wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o,
  output logic        raw_en,
  input  logic        raw_valid,
  input  logic [7:0]  raw_dat
);

  localparam int unsigned FW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned RW = $clog2(RCT_CUTOFF + 1);
  localparam int unsigned WW = $clog2(APT_WINDOW + 1);
  localparam int unsigned CW = $clog2(APT_CUTOFF + 1);

  logic          enable_q, enable_d;
  logic          rct_fail_q, rct_fail_d;
  logic          apt_fail_q, apt_fail_d;
  logic          raw_en_q, raw_en_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [7:0]    dat_q, dat_d;
  logic [7:0]    prev_q, prev_d;
  logic [RW-1:0] rep_q, rep_d;
  logic [7:0]    ref_q, ref_d;
  logic [CW-1:0] apt_cnt_q, apt_cnt_d;
  logic [WW-1:0] win_q, win_d;

  logic          req, fail, accept, clear, ctrl_wr, rd_data, data_err, pop, push, flush;
  logic          rct_trip, apt_trip;
  logic [1:0]    adr;
  logic [7:0]    head, status;
  logic [FW-1:0] fill;
  logic          fifo_empty, fifo_full;
  logic          unused_in;

  assign unused_in = ^{wb_cti_i, wb_bte_i, wb_adr_i[31:2]};

  assign adr      = wb_adr_i[1:0];
  assign req      = wb_cyc_i & wb_stb_i & ~ack_q;
  assign fail     = rct_fail_q | apt_fail_q;
  assign accept   = raw_valid & enable_q & ~fail;
  assign ctrl_wr  = req & wb_we_i & (adr == TRNG_REG_CTRL);
  assign clear    = ctrl_wr & wb_dat_i[CTRL_CLEAR];
  assign rd_data  = req & ~wb_we_i & (adr == TRNG_REG_DATA);
  assign data_err = rd_data & (fifo_empty | fail);
  assign pop      = rd_data & ~data_err;
  assign push     = accept & ~rct_trip & ~apt_trip & ~clear & ~fifo_full;
  // A set fail flag keeps the FIFO flushed from the cycle after the trip
  assign flush    = clear | fail;

  trng_byte_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (wb_clk),
    .rst_ni (wb_rst),
    .flush_i(flush),
    .push_i (push),
    .pop_i  (pop),
    .wdata_i(raw_dat),
    .head_o (head),
    .fill_o (fill),
    .empty_o(fifo_empty),
    .full_o (fifo_full)
  );

  // Health tests; win_q == 0 marks "no sample since reset/clear"
  always_comb begin
    prev_d    = prev_q;
    rep_d     = rep_q;
    ref_d     = ref_q;
    apt_cnt_d = apt_cnt_q;
    win_d     = win_q;
    rct_trip  = 1'b0;
    apt_trip  = 1'b0;
    if (accept) begin
      prev_d = raw_dat;
      if ((win_q != '0) && (raw_dat == prev_q)) rep_d = rep_q + RW'(1);
      else                                      rep_d = RW'(1);
      rct_trip = (rep_d >= RW'(RCT_CUTOFF));
      if ((win_q == '0) || (win_q == WW'(APT_WINDOW))) begin
        ref_d     = raw_dat;
        apt_cnt_d = CW'(1);
        win_d     = WW'(1);
      end else begin
        win_d = win_q + WW'(1);
        if (raw_dat == ref_q) apt_cnt_d = apt_cnt_q + CW'(1);
      end
      apt_trip = (apt_cnt_d >= CW'(APT_CUTOFF));
    end
    if (clear) begin
      prev_d    = 8'h00;
      rep_d     = '0;
      ref_d     = 8'h00;
      apt_cnt_d = '0;
      win_d     = '0;
      rct_trip  = 1'b0;
      apt_trip  = 1'b0;
    end
  end

  always_comb begin
    rct_fail_d = clear ? 1'b0 : (rct_fail_q | rct_trip);
    apt_fail_d = clear ? 1'b0 : (apt_fail_q | apt_trip);
    enable_d   = ctrl_wr ? wb_dat_i[CTRL_ENABLE] : enable_q;
    raw_en_d   = enable_q & ~fail &
                 ((fill < FW'(FIFO_DEPTH - 1)) | ((fill == FW'(FIFO_DEPTH - 1)) & ~push));
  end

  always_comb begin
    status                  = 8'h00;
    status[STATUS_EMPTY]    = fifo_empty;
    status[STATUS_FULL]     = fifo_full;
    status[STATUS_RCT_FAIL] = rct_fail_q;
    status[STATUS_APT_FAIL] = apt_fail_q;
    status[STATUS_ENABLE]   = enable_q;
  end

  always_comb begin
    ack_d = req & ~data_err;
    err_d = data_err;
    dat_d = 8'h00;
    if (req && !wb_we_i) begin
      unique case (adr)
        TRNG_REG_DATA:   dat_d = data_err ? 8'h00 : head;
        TRNG_REG_STATUS: dat_d = status;
        TRNG_REG_LEVEL:  dat_d = 8'(fill);
        TRNG_REG_CTRL:   dat_d = {7'b0, enable_q};
        default:         dat_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rst) begin
      enable_q   <= 1'b0;
      rct_fail_q <= 1'b0;
      apt_fail_q <= 1'b0;
      raw_en_q   <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      dat_q      <= 8'h00;
      prev_q     <= 8'h00;
      rep_q      <= '0;
      ref_q      <= 8'h00;
      apt_cnt_q  <= '0;
      win_q      <= '0;
    end else begin
      enable_q   <= enable_d;
      rct_fail_q <= rct_fail_d;
      apt_fail_q <= apt_fail_d;
      raw_en_q   <= raw_en_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      dat_q      <= dat_d;
      prev_q     <= prev_d;
      rep_q      <= rep_d;
      ref_q      <= ref_d;
      apt_cnt_q  <= apt_cnt_d;
      win_q      <= win_d;
    end
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_rty_o = 1'b0;
  assign raw_en   = raw_en_q;

endmodule
